// File: rtl/sw_reg_wb.sv
// Single 32-bit software register on a Wishbone B3 classic slave, decoded over [C_BASEADDR, C_HIGHADDR].
// Latency 1 cycle (ack/err registered); no backpressure, a held strobe is served every other cycle.
module sw_reg_wb #(
  parameter logic [31:0] C_BASEADDR  = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR  = 32'h0000_FFFF,
  parameter int          C_IO_DIR    = 0,
  parameter logic [31:0] C_RESET_VAL = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] user_data_o,
  input  logic [31:0] user_data_i
);

  logic [31:0] reg_q;
  logic        above_base;
  logic        below_high;
  logic        hit;
  logic        req;

  // Bounds at the ends of the address space are constant-true; skip the compare there.
  if (C_BASEADDR == 32'h0000_0000) begin : g_base_zero
    assign above_base = 1'b1;
  end else begin : g_base_cmp
    assign above_base = (wb_adr_i >= C_BASEADDR);
  end

  if (C_HIGHADDR == 32'hFFFF_FFFF) begin : g_high_max
    assign below_high = 1'b1;
  end else begin : g_high_cmp
    assign below_high = (wb_adr_i <= C_HIGHADDR);
  end

  assign hit = above_base & below_high;
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      reg_q    <= C_RESET_VAL;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'h0000_0000;
    end else begin
      wb_ack_o <= req & hit;
      wb_err_o <= req & ~hit;
      if (req & hit & ~wb_we_i) begin
        wb_dat_o <= (C_IO_DIR != 0) ? user_data_i : reg_q;
      end else begin
        wb_dat_o <= 32'h0000_0000;
      end
      if (C_IO_DIR != 0) begin
        reg_q <= user_data_i;
      end else if (req & hit & wb_we_i) begin
        for (int n = 0; n < 4; n++) begin
          if (wb_sel_i[n]) begin
            reg_q[8*n +: 8] <= wb_dat_i[8*n +: 8];
          end
        end
      end
    end
  end

  assign user_data_o = reg_q;

endmodule

// File: tb/tb_sw_reg_wb.sv
// Directed bench for sw_reg_wb: a processor-write instance and a user-write instance.
module tb_sw_reg_wb;

    logic        clk;
    logic        rst;
    logic        cyc_a, stb_a, cyc_b, stb_b;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat;
    logic [31:0] dat_a, dat_b, user_a, user_b, user_in_b;
    logic        ack_a, err_a, ack_b, err_b;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    sw_reg_wb #(
        .C_BASEADDR (32'h0000_0000),
        .C_HIGHADDR (32'h0000_00FF),
        .C_IO_DIR   (0),
        .C_RESET_VAL(32'h0000_0000)
    ) dut_a (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_cyc_i   (cyc_a),
        .wb_stb_i   (stb_a),
        .wb_we_i    (wb_we),
        .wb_sel_i   (wb_sel),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat),
        .wb_dat_o   (dat_a),
        .wb_ack_o   (ack_a),
        .wb_err_o   (err_a),
        .user_data_o(user_a),
        .user_data_i(32'h0000_0000)
    );

    sw_reg_wb #(
        .C_BASEADDR (32'h0000_1000),
        .C_HIGHADDR (32'h0000_1FFF),
        .C_IO_DIR   (1),
        .C_RESET_VAL(32'h5A5A_0000)
    ) dut_b (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_cyc_i   (cyc_b),
        .wb_stb_i   (stb_b),
        .wb_we_i    (wb_we),
        .wb_sel_i   (wb_sel),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat),
        .wb_dat_o   (dat_b),
        .wb_ack_o   (ack_b),
        .wb_err_o   (err_b),
        .user_data_o(user_b),
        .user_data_i(user_in_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then drop the strobe.
    task automatic strobe(input bit which, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
        wb_we  = we;
        wb_sel = sel;
        wb_adr = adr;
        wb_dat = dat;
        if (which) begin
            cyc_b = 1'b1; stb_b = 1'b1;
        end else begin
            cyc_a = 1'b1; stb_a = 1'b1;
        end
        tick();
        cyc_a = 1'b0; stb_a = 1'b0;
        cyc_b = 1'b0; stb_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
        wb_we = 1'b0; wb_sel = 4'h0; wb_adr = 32'h0; wb_dat = 32'h0;
        user_in_b = 32'hA5A5_A5A5;
        repeat (3) tick();

        chk("rst_ack_a", ack_a, 1'b0);
        chk("rst_err_a", err_a, 1'b0);
        chk("rst_dat_a", dat_a, 32'h0000_0000);
        chk("rst_user_a", user_a, 32'h0000_0000);
        chk("rst_user_b", user_b, 32'h5A5A_0000);
        chk("rst_ack_b", ack_b, 1'b0);

        rst = 1'b0;
        tick();
        chk("user_b_tracks", user_b, 32'hA5A5_A5A5);

        // First read after reset
        strobe(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
        chk("rd0_ack", ack_a, 1'b1);
        chk("rd0_err", err_a, 1'b0);
        chk("rd0_dat", dat_a, 32'h0000_0000);
        tick();
        chk("rd0_ack_drop", ack_a, 1'b0);

        // Partial byte-lane write
        strobe(0, 1'b1, 4'hE, 32'h0000_0004, 32'hEEEE_EEEE);
        chk("wr_e_ack", ack_a, 1'b1);
        chk("wr_e_user", user_a, 32'hEEEE_EE00);
        tick();
        chk("wr_e_one_pulse", ack_a, 1'b0);
        strobe(0, 1'b0, 4'h1, 32'h0000_0080, 32'h0);
        chk("rd_e_dat", dat_a, 32'hEEEE_EE00);
        tick();
        chk("rd_e_dat_clear", dat_a, 32'h0000_0000);

        // Full write then low-lane overwrite
        strobe(0, 1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678);
        chk("wr_f_user", user_a, 32'h1234_5678);
        tick();
        strobe(0, 1'b1, 4'h1, 32'h0000_00FC, 32'hFFFF_FFFF);
        chk("wr_1_ack", ack_a, 1'b1);
        tick();
        strobe(0, 1'b0, 4'h0, 32'h0000_00FF, 32'h0);
        chk("rd_mix_dat", dat_a, 32'h1234_56FF);
        tick();

        // Held read strobe: ack every other cycle
        wb_we = 1'b0; wb_adr = 32'h0000_0010; cyc_a = 1'b1; stb_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("hold_ack", ack_a, (i % 2 == 0));
            chk("hold_dat", dat_a, (i % 2 == 0) ? 32'h1234_56FF : 32'h0000_0000);
            chk("hold_err", err_a, 1'b0);
        end
        cyc_a = 1'b0; stb_a = 1'b0;
        tick();

        // Out-of-window write
        strobe(0, 1'b1, 4'hF, 32'h0000_0100, 32'h0000_0000);
        chk("oob_err", err_a, 1'b1);
        chk("oob_ack", ack_a, 1'b0);
        chk("oob_dat", dat_a, 32'h0000_0000);
        chk("oob_user", user_a, 32'h1234_56FF);
        tick();
        chk("oob_err_drop", err_a, 1'b0);

        // cyc without stb, and stb without cyc
        wb_we = 1'b1; wb_sel = 4'hF; wb_adr = 32'h0; wb_dat = 32'hCAFE_F00D;
        cyc_a = 1'b1; stb_a = 1'b0;
        tick();
        chk("cyc_only_ack", ack_a, 1'b0);
        cyc_a = 1'b0; stb_a = 1'b1; wb_adr = 32'h0000_0200;
        tick();
        chk("stb_only_err", err_a, 1'b0);
        chk("no_req_user", user_a, 32'h1234_56FF);
        stb_a = 1'b0;
        tick();

        // Processor write into the user-driven register is acked but ignored
        strobe(1, 1'b1, 4'hF, 32'h0000_1000, 32'h0000_0000);
        chk("b_wr_ack", ack_b, 1'b1);
        chk("b_wr_user", user_b, 32'hA5A5_A5A5);
        tick();
        strobe(1, 1'b0, 4'hF, 32'h0000_1FFC, 32'h0);
        chk("b_rd_dat", dat_b, 32'hA5A5_A5A5);
        tick();
        user_in_b = 32'h0F0F_1234;
        strobe(1, 1'b0, 4'hF, 32'h0000_1800, 32'h0);
        chk("b_rd_new", dat_b, 32'h0F0F_1234);
        tick();
        strobe(1, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0);
        chk("b_below_err", err_b, 1'b1);
        chk("b_below_dat", dat_b, 32'h0000_0000);
        tick();
        strobe(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
        chk("b_above_err", err_b, 1'b1);
        chk("b_above_ack", ack_b, 1'b0);
        tick();

        // Reset during a held read strobe
        wb_we = 1'b0; wb_adr = 32'h0000_1004; cyc_b = 1'b1; stb_b = 1'b1;
        tick();
        chk("b_hold_ack", ack_b, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        chk("b_rst_ack", ack_b, 1'b0);
        chk("b_rst_err", err_b, 1'b0);
        chk("b_rst_dat", dat_b, 32'h0000_0000);
        chk("b_rst_user", user_b, 32'h5A5A_0000);
        cyc_b = 1'b0; stb_b = 1'b0;
        rst = 1'b0;
        tick();

        // Reset has priority over a write presented on the same edge
        wb_we = 1'b1; wb_sel = 4'hF; wb_adr = 32'h0; wb_dat = 32'hDEAD_BEEF;
        cyc_a = 1'b1; stb_a = 1'b1; rst = 1'b1;
        tick();
        chk("a_rst_wr_ack", ack_a, 1'b0);
        chk("a_rst_wr_user", user_a, 32'h0000_0000);
        cyc_a = 1'b0; stb_a = 1'b0; rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
